ram_ctrl: RTL and testbench

- Burst-capable request/response controller that sits directly upstream of the single-port RAM.
- Accepts read or write bursts on a valid/ready request port and streams write data in.
- Drives the RAM's `wen`/`addr` and shared bidirectional `data` bus, and returns read data on a valid/ready response port.
- Guarantees the controller drives the shared bus only while `mem_wen` is high, so there is no contention with the RAM's read driver.

---
 rtl/ram_ctrl_pkg.sv | 13 +
 rtl/ram_ctrl.sv | 114 +++++++++++
 tb/tb_ram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types for the burst RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_FETCH = 2'd2,
    RD_RESP  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Burst request/response controller in front of a single-port RAM with a
// shared bidirectional data bus; only drives the bus while mem_wen is high.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = 4,
  parameter int unsigned data_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [addr_width-1:0] req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  mem_wen,
  output logic [addr_width-1:0] mem_addr,
  inout  wire  [data_width-1:0] mem_data
);

  ctrl_state_t           state_q, state_d;
  logic [addr_width-1:0] cur_addr_q, cur_addr_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [data_width-1:0] rd_data_q, rd_data_d;
  logic                  rd_last_q, rd_last_d;
  logic                  rd_valid_q, busy_q;

  // Bus is released whenever the RAM is not being written
  assign mem_data = mem_wen ? wr_data : {data_width{1'bz}};

  assign mem_addr = cur_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      rd_valid_q <= (state_d == RD_RESP);
      busy_q     <= (state_d != IDLE);
    end
  end

  // Next-state, datapath updates and the combinational handshake outputs
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_wen    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          cur_addr_d = req_addr;
          cnt_d      = req_len;
          state_d    = req_write ? WRITE : RD_FETCH;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        mem_wen  = wr_valid;
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + addr_width'(1);
          cnt_d      = cnt_q - addr_width'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      RD_FETCH: begin
        rd_data_d = mem_data;
        rd_last_d = (cnt_q == '0);
        state_d   = RD_RESP;
      end
      RD_RESP: begin
        if (rd_ready) begin
          if (rd_last_q) begin
            state_d = IDLE;
          end else begin
            cur_addr_d = cur_addr_q + addr_width'(1);
            cnt_d      = cnt_q - addr_width'(1);
            state_d    = RD_FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: controller plus a behavioural single-port RAM on a shared
// bus; write/read scoreboards checked by monitors decoupled from stimulus.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [3:0] rd_data;
  logic       busy, mem_wen;
  logic [3:0] mem_addr;
  wire  [3:0] mem_data;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_ent_t;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } rd_ent_t;

  wr_ent_t wr_exp[$];
  rd_ent_t rd_exp[$];
  int      errors = 0;
  int      checks = 0;
  int      wen_cnt = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.addr_width(4), .data_width(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // Behavioural RAM: async read driver, write on rising edge, active-low reset
  logic [3:0] ram [16];
  wire        ram_rst_n = !rst;

  assign mem_data = (ram_rst_n && !mem_wen) ? ram[mem_addr] : 4'bzzzz;

  always @(posedge clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'h0;
    end else if (mem_wen) begin
      ram[mem_addr] <= mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor and bus-ownership monitor
  always @(negedge clk) begin : wr_mon
    wr_ent_t e;
    if (mem_wen) begin
      wen_cnt++;
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: addr %0h data %0h, expected no write", mem_addr, mem_data);
      end else begin
        e = wr_exp.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_data), 32'(e.data));
      end
      chk("bus_ctrl_drive", 32'(mem_data), 32'(wr_data));
    end else if (!rst) begin
      chk("bus_ram_drive", 32'(mem_data), 32'(ram[mem_addr]));
    end
  end

  // Read response monitor
  always @(negedge clk) begin : rd_mon
    rd_ent_t e;
    if (rd_valid && rd_ready) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: data %0h last %0b, expected no beat", rd_data, rd_last);
      end else begin
        e = rd_exp.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_last", 32'(rd_last), 32'(e.last));
      end
    end
  end

  task automatic do_req(input logic w, input logic [3:0] a, input logic [3:0] l);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = ~a;
    req_len   = ~l;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [3:0] len,
                          input logic [3:0] d [4], input int gap_at, input int gap);
    int start;
    start = wen_cnt;
    for (int i = 0; i <= int'(len); i++) wr_exp.push_back({4'(addr + 4'(i)), d[i]});
    do_req(1'b1, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == gap_at) begin
        repeat (gap) begin
          wr_valid = 1'b0;
          @(negedge clk);
          chk("gap_wen", 32'(mem_wen), 32'd0);
          chk("gap_busy", 32'(busy), 32'd1);
          @(posedge clk); #1;
        end
      end
      wr_valid = 1'b1;
      wr_data  = d[b];
      @(negedge clk);
      if (b == 0) chk("wr_busy_rise", 32'(busy), 32'd1);
      chk("wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wr_data  = 4'hF;
    @(negedge clk);
    chk("wr_done_req_ready", 32'(req_ready), 32'd1);
    chk("wr_done_busy", 32'(busy), 32'd0);
    chk("wr_wen_cycles", 32'(wen_cnt - start), 32'(int'(len) + 1));
    for (int i = 0; i <= int'(len); i++) chk("ram_content", 32'(ram[4'(addr + 4'(i))]), 32'(d[i]));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [3:0] len,
                         input logic [3:0] d [4], input int stall_at, input int stall);
    for (int i = 0; i <= int'(len); i++) rd_exp.push_back({d[i], i == int'(len)});
    rd_ready = 1'b1;
    do_req(1'b0, addr, len);
    @(negedge clk);
    chk("rd_fetch0_valid", 32'(rd_valid), 32'd0);
    chk("rd_busy_rise", 32'(busy), 32'd1);
    @(posedge clk); #1;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) begin
        @(negedge clk);
        chk("rd_fetch_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
      end
      if (b == stall_at) begin
        rd_ready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("stall_valid", 32'(rd_valid), 32'd1);
          chk("stall_data", 32'(rd_data), 32'(d[b]));
          chk("stall_last", 32'(rd_last), 32'(b == int'(len)));
          chk("stall_addr", 32'(mem_addr), 32'(4'(addr + 4'(b))));
          @(posedge clk); #1;
        end
        rd_ready = 1'b1;
      end
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'd1);
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rd_done_req_ready", 32'(req_ready), 32'd1);
    chk("rd_done_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] v [4];
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 4'h0;
    req_len   = 4'h0;
    wr_valid  = 1'b0;
    wr_data   = 4'h0;
    rd_ready  = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Request fields without req_valid must not start a burst
    req_write = 1'b1;
    req_addr  = 4'h7;
    wr_valid  = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("no_hs_busy", 32'(busy), 32'd0);
    chk("no_hs_wr_ready", 32'(wr_ready), 32'd0);
    chk("no_hs_wen", 32'(mem_wen), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;

    v = '{4'hA, 4'hB, 4'hC, 4'hD};
    do_write(4'd2, 4'd3, v, -1, 0);
    do_read(4'd2, 4'd3, v, -1, 0);

    v = '{4'h1, 4'h2, 4'h3, 4'h4};
    do_write(4'd14, 4'd3, v, -1, 0);
    @(negedge clk);
    chk("wrap_ram15", 32'(ram[15]), 32'h2);
    chk("wrap_ram0", 32'(ram[0]), 32'h3);
    @(posedge clk); #1;
    do_read(4'd14, 4'd3, v, -1, 0);

    v = '{4'hA, 4'hB, 4'hC, 4'hD};
    do_read(4'd2, 4'd3, v, 1, 5);

    v = '{4'h7, 4'h8, 4'h9, 4'h0};
    do_write(4'd8, 4'd2, v, 1, 3);
    do_read(4'd8, 4'd2, v, -1, 0);

    // Reset in the middle of a 4-beat write after two beats
    wr_exp.push_back({4'd4, 4'h5});
    wr_exp.push_back({4'd5, 4'h6});
    do_req(1'b1, 4'd4, 4'd3);
    wr_valid = 1'b1;
    wr_data  = 4'h5;
    @(negedge clk);
    @(posedge clk); #1;
    wr_data = 4'h6;
    @(negedge clk);
    @(posedge clk); #1;
    wr_data = 4'h7;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_wen", 32'(mem_wen), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    wr_data = 4'h8;
    @(negedge clk);
    chk("midrst_hold_wen", 32'(mem_wen), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_wr_ready", 32'(wr_ready), 32'd0);
    chk("rel_wen", 32'(mem_wen), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("aborted_ram6", 32'(ram[6]), 32'h0);
    chk("aborted_ram7", 32'(ram[7]), 32'h0);
    @(posedge clk); #1;

    v = '{4'h9, 4'hE, 4'h0, 4'h0};
    do_write(4'd0, 4'd1, v, -1, 0);
    do_read(4'd0, 4'd1, v, -1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("wr_queue_empty", 32'(wr_exp.size()), 32'd0);
    chk("rd_queue_empty", 32'(rd_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
